// File: rtl/ifetch_unit.sv
// ifetch_unit
//   Instruction fetch stage: initiator side of the instruction-memory read
//   port. Holds the fetch PC, presents it as a byte address to a word-indexed
//   memory that answers combinationally, and captures the returned word into
//   a one-entry output register handed to decode over valid/ready.
//
//   Ports
//     clk            rising-edge clock
//     rst            asynchronous active-high reset
//     icache_addr    byte address to instruction memory (equals fetch PC)
//     icache_data    instruction word returned in the same cycle
//     redirect_valid load redirect_pc as the new fetch PC, flushing output
//     redirect_pc    redirect target (byte address)
//     if_valid       output register holds an instruction for decode
//     if_ready       decode accepts the instruction this cycle
//     if_instr       captured instruction (NOP on a fault entry)
//     if_pc          PC of if_instr
//     if_pc_plus4    if_pc + 4, modulo 2^32
//     if_fault       captured entry is a misaligned/out-of-range fetch fault
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_DEP  = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_fault
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  // Byte size of memory, widened to 33 bits so 4*MEM_DEP cannot overflow.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEP) << 2;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc, fpc_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        fault_d;
  logic        fault_now;
  logic        capture;

  function automatic logic fetch_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || ({1'b0, pc} >= MEM_BYTES);
  endfunction

  assign icache_addr = fpc;
  assign if_pc_plus4 = if_pc + 32'd4;

  // Stage p0: address out, combinational data back, decide next state
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc;
    valid_d   = if_valid;
    instr_d   = if_instr;
    pc_d      = if_pc;
    fault_d   = if_fault;
    fault_now = fetch_fault(fpc);
    capture   = (state_q == RUN) && !redirect_valid && (!if_valid || if_ready);

    if (redirect_valid) begin
      // Redirect wins over any handshake in the same cycle; the pending
      // entry is dropped even if decode is asserting ready.
      fpc_d   = redirect_pc;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (capture) begin
      valid_d = 1'b1;
      pc_d    = fpc;
      fault_d = fault_now;
      instr_d = fault_now ? NOP_INSTR : icache_data;
      if (fault_now) begin
        // Hold the faulting PC and stop fetching until redirected.
        state_d = HALT;
      end else begin
        fpc_d = fpc + 32'd4;
      end
    end else if (if_valid && if_ready) begin
      valid_d = 1'b0;
    end
  end

  // Stage p1: output register to decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      fpc      <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
      if_fault <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc      <= fpc_d;
      if_valid <= valid_d;
      if_instr <= instr_d;
      if_pc    <= pc_d;
      if_fault <= fault_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam int MEM_DEP = 64;

  logic        clk;
  logic        rst;
  logic [31:0] icache_addr;
  logic [31:0] icache_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_fault;

  logic [31:0] mem [MEM_DEP];

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction view of the fetch stage)
  logic [31:0] m_fpc;
  bit          m_halt;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          m_fault;

  ifetch_unit #(.RESET_PC(32'h0), .MEM_DEP(MEM_DEP)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_addr    (icache_addr),
    .icache_data    (icache_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_fault       (if_fault)
  );

  // Out-of-range reads return junk so a fault entry that leaks data shows up.
  assign icache_data = (icache_addr < 32'(4 * MEM_DEP)) ? mem[icache_addr[7:2]]
                                                        : 32'hBAD0_BAD0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'(4 * MEM_DEP)) return mem[int'(a / 4)];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic model_reset();
    m_fpc   = 32'h0;
    m_halt  = 1'b0;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_pc    = 32'h0;
    m_fault = 1'b0;
  endtask

  task automatic model_step();
    bit bad;
    if (redirect_valid) begin
      m_fpc   = redirect_pc;
      m_valid = 1'b0;
      m_halt  = 1'b0;
    end else if (!m_halt && (!m_valid || if_ready)) begin
      bad     = (m_fpc % 4 != 0) || (longint'(m_fpc) >= longint'(4 * MEM_DEP));
      m_valid = 1'b1;
      m_pc    = m_fpc;
      m_fault = bad;
      m_instr = bad ? 32'h13 : model_read(m_fpc);
      if (bad) m_halt = 1'b1;
      else     m_fpc  = m_fpc + 32'd4;
    end else if (m_valid && if_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("if_valid",    32'(if_valid),  32'(m_valid));
    check("if_pc",       if_pc,          m_pc);
    check("if_instr",    if_instr,       m_instr);
    check("if_fault",    32'(if_fault),  32'(m_fault));
    check("if_pc_plus4", if_pc_plus4,    m_pc + 32'd4);
    check("icache_addr", icache_addr,    m_fpc);
  endtask

  // Inputs applied at the falling edge, outputs compared at the next one.
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 9))
      0:       return 32'd252;
      1:       return 32'd248;
      2:       return 32'd6;
      3:       return 32'd256;
      4:       return 32'hFFFF_FFFC;
      5:       return $urandom();
      default: return 32'($urandom_range(0, MEM_DEP - 1)) * 4;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < MEM_DEP; i++) mem[i] = 32'hA500_0000 + 32'(i * 17) + ($urandom() & 32'h00FF_0000);
    rst            = 1'b1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Sequential stream from RESET_PC
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0);

    // Back-pressure while pc 8 is presented
    cycle(1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    check("bp_pc8", if_pc, 32'd8);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    check("bp_hold_addr", icache_addr, 32'd12);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);

    // Redirect with ready high, then with ready low
    cycle(1'b1, 1'b1, 32'd32);
    cycle(1'b1, 1'b0, 32'h0);
    check("redir_instr", if_instr, mem[8]);
    cycle(1'b0, 1'b1, 32'd32);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);

    // Range fault at the top of memory, then resume from 0
    cycle(1'b1, 1'b1, 32'd244);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'd244);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect
    cycle(1'b1, 1'b1, 32'd6);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

    // Asynchronous reset pulse mid-stall
    cycle(1'b1, 1'b1, 32'd40);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #1 model_reset();
    compare_all();
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit rv;
      rv = ($urandom_range(0, 99) < (m_halt ? 25 : 6));
      cycle(($urandom_range(0, 99) < 70), rv, rv ? pick_target() : $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
